// File: rtl/acc_pc_unit_if.sv
// Operand/jump inputs and accumulator/PC outputs of acc_pc_unit grouped into one bus.
// The master drives operands and jumps; the slave (the unit) drives the results.
interface acc_pc_unit_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] data_in;
    logic             jump;
    logic [WIDTH-1:0] jump_addr;
    logic [WIDTH-1:0] acc;
    logic             acc_carry;
    logic             acc_zero;
    logic [WIDTH-1:0] pc;

    modport master (
        output data_in, jump, jump_addr,
        input  acc, acc_carry, acc_zero, pc
    );

    modport slave (
        input  data_in, jump, jump_addr,
        output acc, acc_carry, acc_zero, pc
    );
endinterface

// File: rtl/acc_pc_unit.sv
// Free-running accumulator with carry-out plus program counter with jump load.
// Both registers update on every rising edge and clear asynchronously on reset=0.
module acc_pc_unit #(
    parameter int WIDTH    = 16,
    parameter int PC_STEP  = 1,
    parameter int PC_RESET = 0
) (
    input  logic         clk,
    input  logic         reset,
    acc_pc_unit_if.slave bus
);
    localparam logic [WIDTH-1:0] PC_STEP_V  = WIDTH'(PC_STEP);
    localparam logic [WIDTH-1:0] PC_RESET_V = WIDTH'(PC_RESET);

    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_pc_next;

    // One extra bit so the carry-out falls out of the same adder.
    assign w_sum     = {1'b0, r_acc} + {1'b0, bus.data_in};
    assign w_pc_next = bus.jump ? bus.jump_addr : (r_pc + PC_STEP_V);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_pc    <= PC_RESET_V;
        end else begin
            r_acc   <= w_sum[WIDTH-1:0];
            r_carry <= w_sum[WIDTH];
            r_pc    <= w_pc_next;
        end
    end

    assign bus.acc       = r_acc;
    assign bus.acc_carry = r_carry;
    assign bus.acc_zero  = (r_acc == '0);
    assign bus.pc        = r_pc;
endmodule

// File: tb/tb_acc_pc_unit.sv
// Self-checking bench for acc_pc_unit: directed vector table, async reset corner
// cases, and a randomized run against an arithmetic reference model.
module tb_acc_pc_unit;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    acc_pc_unit_if #(.WIDTH(16)) bus ();

    acc_pc_unit #(.WIDTH(16), .PC_STEP(1), .PC_RESET(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] din;
        logic        jmp;
        logic [15:0] addr;
        logic [15:0] e_acc;
        logic        e_carry;
        logic        e_zero;
        logic [15:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] e_acc, input logic e_carry,
                             input logic e_zero, input logic [15:0] e_pc);
        check({tag, " acc"},   {16'h0, bus.acc},        {16'h0, e_acc});
        check({tag, " carry"}, {31'h0, bus.acc_carry},  {31'h0, e_carry});
        check({tag, " zero"},  {31'h0, bus.acc_zero},   {31'h0, e_zero});
        check({tag, " pc"},    {16'h0, bus.pc},         {16'h0, e_pc});
    endtask

    // Reference model state: plain modular arithmetic on ints.
    int m_acc;
    int m_carry;
    int m_pc;

    initial begin
        checks = 0;
        errors = 0;
        reset         = 1'b0;
        bus.data_in   = 16'h1234;
        bus.jump      = 1'b1;
        bus.jump_addr = 16'h5678;
        #1;
        check_all("reset-before-edge", 16'h0000, 1'b0, 1'b1, 16'h0000);

        // rst, din, jmp, addr, acc, carry, zero, pc
        vecs.push_back('{1'b0, 16'h1234, 1'b1, 16'h5678, 16'h0000, 1'b0, 1'b1, 16'h0000});
        vecs.push_back('{1'b0, 16'h1234, 1'b1, 16'h5678, 16'h0000, 1'b0, 1'b1, 16'h0000});
        vecs.push_back('{1'b0, 16'h1234, 1'b1, 16'h5678, 16'h0000, 1'b0, 1'b1, 16'h0000});
        vecs.push_back('{1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001});
        vecs.push_back('{1'b1, 16'h1234, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b0, 16'h0002});
        vecs.push_back('{1'b1, 16'h9ABC, 1'b1, 16'h5678, 16'hACF0, 1'b0, 1'b0, 16'h5678});
        vecs.push_back('{1'b1, 16'h9ABC, 1'b0, 16'h0000, 16'h47AC, 1'b1, 1'b0, 16'h5679});
        vecs.push_back('{1'b1, 16'h0000, 1'b0, 16'h0000, 16'h47AC, 1'b0, 1'b0, 16'h567A});
        vecs.push_back('{1'b1, 16'h0000, 1'b1, 16'h1234, 16'h47AC, 1'b0, 1'b0, 16'h1234});
        vecs.push_back('{1'b1, 16'h0000, 1'b1, 16'h1234, 16'h47AC, 1'b0, 1'b0, 16'h1234});
        vecs.push_back('{1'b1, 16'h0000, 1'b1, 16'h1234, 16'h47AC, 1'b0, 1'b0, 16'h1234});
        vecs.push_back('{1'b1, 16'h0000, 1'b1, 16'hFFFF, 16'h47AC, 1'b0, 1'b0, 16'hFFFF});
        vecs.push_back('{1'b1, 16'h0000, 1'b0, 16'h0000, 16'h47AC, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 16'h3333, 16'h0000, 1'b0, 1'b1, 16'h0000});
        vecs.push_back('{1'b1, 16'h0005, 1'b0, 16'h0000, 16'h0005, 1'b0, 1'b0, 16'h0001});
        vecs.push_back('{1'b1, 16'h0010, 1'b1, 16'h00A0, 16'h0015, 1'b0, 1'b0, 16'h00A0});
        vecs.push_back('{1'b1, 16'hFFEB, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h00A1});

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            reset         = vecs[i].rst;
            bus.data_in   = vecs[i].din;
            bus.jump      = vecs[i].jmp;
            bus.jump_addr = vecs[i].addr;
            @(posedge clk);
            @(negedge clk);
            $display("vec %0d: rst=%0d din=%h jmp=%0d addr=%h -> acc=%h c=%0d z=%0d pc=%h",
                     i, reset, bus.data_in, bus.jump, bus.jump_addr,
                     bus.acc, bus.acc_carry, bus.acc_zero, bus.pc);
            check_all($sformatf("vec%0d", i), vecs[i].e_acc, vecs[i].e_carry,
                      vecs[i].e_zero, vecs[i].e_pc);
        end

        // Mid-cycle assertion: outputs must clear without waiting for an edge.
        bus.data_in = 16'h0003;
        bus.jump    = 1'b0;
        @(posedge clk);
        #2;
        check_all("pre-midreset", 16'h0003, 1'b0, 1'b0, 16'h00A2);
        reset = 1'b0;
        #1;
        $display("mid-cycle reset: acc=%h c=%0d z=%0d pc=%h",
                 bus.acc, bus.acc_carry, bus.acc_zero, bus.pc);
        check_all("midreset", 16'h0000, 1'b0, 1'b1, 16'h0000);

        // Release between edges: first update only at the next rising edge.
        @(negedge clk);
        reset       = 1'b1;
        bus.data_in = 16'h0007;
        #2;
        check_all("release-no-edge", 16'h0000, 1'b0, 1'b1, 16'h0000);
        // Input change between edges must be ignored; last value before edge counts.
        bus.data_in = 16'h0009;
        @(posedge clk);
        #1;
        $display("post-release edge: acc=%h pc=%h", bus.acc, bus.pc);
        check_all("release-first-edge", 16'h0009, 1'b0, 1'b0, 16'h0001);

        // Randomized run against the arithmetic model.
        m_acc = 9; m_carry = 0; m_pc = 1;
        for (int n = 0; n < 300; n++) begin
            int d, a, j, r, sum;
            @(negedge clk);
            case ($urandom_range(0, 3))
                0:       d = 0;
                1:       d = 16'hFFFF;
                default: d = int'($urandom_range(0, 65535));
            endcase
            a = ($urandom_range(0, 7) == 0) ? 65535 : int'($urandom_range(0, 65535));
            j = ($urandom_range(0, 3) == 0) ? 1 : 0;
            r = ($urandom_range(0, 24) == 0) ? 1 : 0;
            reset         = (r == 0);
            bus.data_in   = 16'(d);
            bus.jump      = (j != 0);
            bus.jump_addr = 16'(a);
            if (r != 0) begin
                m_acc = 0; m_carry = 0; m_pc = 0;
            end else begin
                sum     = m_acc + d;
                m_acc   = sum % 65536;
                m_carry = (sum >= 65536) ? 1 : 0;
                m_pc    = (j != 0) ? a : (m_pc + 1) % 65536;
            end
            @(posedge clk);
            #1;
            $display("rnd %0d: rst=%0d din=%h jmp=%0d addr=%h -> acc=%h c=%0d pc=%h",
                     n, r == 0, d[15:0], j, a[15:0], bus.acc, bus.acc_carry, bus.pc);
            check_all($sformatf("rnd%0d", n), 16'(m_acc), m_carry[0],
                      (m_acc == 0), 16'(m_pc));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/acc_pc_unit.md
Name:
acc_pc_unit

Overview:
- Datapath core element combining a 16-bit accumulator and a 16-bit program counter, clocked together.
- Every clock the accumulator adds the data input to its running value.
- Every clock the program counter either increments or, on a jump request, loads a jump target.
- Sits between the instruction/operand fetch logic and the execute stage of the team's simple accumulator CPU.

Parameters:
- WIDTH, 16, data path width of accumulator, data input, PC and jump address.
- PC_STEP, 1, amount added to the PC on each non-jump cycle.
- PC_RESET, 0, PC value loaded on reset.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 clears state immediately).
- data_in  input  WIDTH  operand added into the accumulator each cycle.
- jump  input  1  when 1 at a rising edge, the PC loads jump_addr.
- jump_addr  input  WIDTH  jump target.
- acc  output  WIDTH  registered accumulator value.
- acc_carry  output  1  registered carry-out of the most recent accumulate.
- acc_zero  output  1  combinational flag, 1 when acc == 0.
- pc  output  WIDTH  registered program counter.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. The ports are named clk and reset.
- Reset:
  - While reset=0, acc=0, acc_carry=0 and pc=PC_RESET, regardless of clk.
  - Assertion takes effect without waiting for an edge.
  - Deassertion is sampled at the next rising edge; the first update occurs at the first rising edge with reset=1.
  - Reset mid-operation discards all accumulated state and any pending jump.
- Accumulator, each rising edge with reset=1:
  - {acc_carry, acc} <= acc + data_in, computed at WIDTH+1 bits.
  - acc keeps the low WIDTH bits (wraps modulo 2^WIDTH); acc_carry keeps bit WIDTH.
  - Latency is one cycle: data_in present before edge N is reflected in acc after edge N.
  - There is no enable. Holding data_in=0 holds acc and clears acc_carry.
- acc_zero follows acc combinationally, including during reset (reads 1).
- Program counter, each rising edge with reset=1:
  - jump=1: pc <= jump_addr.
  - jump=0: pc <= pc + PC_STEP, wrapping modulo 2^WIDTH (0xFFFF -> 0x0000 with defaults).
  - jump held high on consecutive edges reloads jump_addr every edge; pc does not increment.
  - jump and the accumulator update are independent. Simultaneous jump and data_in activity both take effect on the same edge.
- All outputs are registered except acc_zero. There are no combinational paths from inputs to acc, acc_carry or pc.
- Inputs are sampled only at rising edges. Changes between edges have no effect.

Test Plan:
- Reset: hold reset=0 with data_in=0x1234, jump=1, jump_addr=0x5678 across several edges -> acc=0x0000, acc_carry=0, acc_zero=1, pc=0x0000 throughout. Mid-cycle assertion clears outputs immediately.
- Accumulate: release reset, apply data_in=0x0000 for one edge, then 0x1234 for one edge -> acc=0x1234, acc_zero=0, acc_carry=0. Then data_in=0x9ABC for one edge -> acc=0xACF0, carry=0.
- Accumulator wrap: from acc=0xACF0, another edge with data_in=0x9ABC -> acc=0x47AC, acc_carry=1. Next edge with data_in=0 -> acc=0x47AC, acc_carry=0.
- PC increment and jump: after reset release, pc=0x0001, 0x0002 on successive edges. Assert jump=1 with jump_addr=0x5678 for one edge -> pc=0x5678. Deassert jump -> 0x5679, 0x567A.
- Held jump and PC wrap: jump=1 with jump_addr=0x1234 for three edges -> pc stays 0x1234. Then jump=1 with jump_addr=0xFFFF for one edge and jump=0 -> pc=0xFFFF, then 0x0000.
- Concurrency: on the same edge apply jump=1 (jump_addr=0x00A0) and data_in=0x0010 from acc=0x0005 -> pc=0x00A0 and acc=0x0015 together.
